// File: rtl/display_pkg.sv
// Shared types and constants for the binary-to-7-segment display path.
package display_pkg;

  typedef enum logic [1:0] {IDLE, CONV, DONE} conv_state_t;

  // Active-low segment patterns {g,f,e,d,c,b,a} for digits 0..9.
  localparam logic [6:0] SEG_LUT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  localparam logic [6:0] SEG_BLANK   = 7'b1111111;
  localparam logic [1:0] DIGIT_UNITS = 2'b10;
  localparam logic [1:0] DIGIT_TENS  = 2'b01;
  localparam logic [1:0] DIGIT_OFF   = 2'b11;

  // Double-dabble correction: a nibble of 5 or more would overflow past 9
  // on the next shift, so pre-add 3.
  function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
    if (nib >= 4'd5) return nib + 4'd3;
    return nib;
  endfunction

endpackage

// File: rtl/module_bin2bcd.sv
// Iterative double-dabble converter: 6-bit binary to two BCD digits.
// One shift per cycle; re-converts whenever the input differs from the
// last value it converted.
module module_bin2bcd
  import display_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] count_i,
  output logic       busy_o,
  output logic [3:0] bcd_tens_o,
  output logic [3:0] bcd_units_o
);

  conv_state_t state_q, state_d;
  logic [5:0]  last_q, last_d;
  logic [2:0]  iter_q, iter_d;
  // {tens[13:10], units[9:6], binary[5:0]}
  logic [13:0] shreg_q, shreg_d;
  logic [13:0] adj;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  units_q, units_d;

  // Next-state and datapath update for the conversion FSM.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    iter_d  = iter_q;
    shreg_d = shreg_q;
    tens_d  = tens_q;
    units_d = units_q;
    adj     = shreg_q;
    case (state_q)
      IDLE: begin
        if (count_i != last_q) begin
          shreg_d = {8'h00, count_i};
          last_d  = count_i;
          iter_d  = 3'd0;
          state_d = CONV;
        end
      end
      CONV: begin
        adj     = {dd_adjust(shreg_q[13:10]), dd_adjust(shreg_q[9:6]), shreg_q[5:0]};
        shreg_d = {adj[12:0], 1'b0};
        iter_d  = iter_q + 3'd1;
        if (iter_q == 3'd5) state_d = DONE;
      end
      DONE: begin
        tens_d  = shreg_q[13:10];
        units_d = shreg_q[9:6];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and data registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= '0;
      iter_q  <= '0;
      shreg_q <= '0;
      tens_q  <= '0;
      units_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      iter_q  <= iter_d;
      shreg_q <= shreg_d;
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign bcd_tens_o  = tens_q;
  assign bcd_units_o = units_q;

endmodule

// File: rtl/module_bin2seg_mux.sv
// Two-digit multiplexed common-anode 7-segment driver for a 6-bit count.
// Converts to BCD, alternates the lit digit every REFRESH_CYCLES clocks and
// registers anode and segment drive together so they switch on one edge.
module module_bin2seg_mux
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_CYCLES = 27000,
  parameter bit          BLANK_ZERO     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] count_i,
  output logic       busy_o,
  output logic [3:0] bcd_tens_o,
  output logic [3:0] bcd_units_o,
  output logic [6:0] seg_o,
  output logic [1:0] an_o
);

  localparam int unsigned CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

  logic [3:0] tens, units;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic sel_q, sel_d;
  logic [6:0] seg_q, seg_d;
  logic [1:0] an_q, an_d;

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    if (d <= 4'd9) return SEG_LUT[d];
    return SEG_BLANK;
  endfunction

  module_bin2bcd u_bin2bcd (
    .clk         (clk),
    .rst         (rst),
    .count_i     (count_i),
    .busy_o      (busy_o),
    .bcd_tens_o  (tens),
    .bcd_units_o (units)
  );

  // Refresh counter wraps every REFRESH_CYCLES clocks and flips the digit select.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    sel_d = sel_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      sel_d = ~sel_q;
    end
  end

  // Segment mux driven from the current select; optional leading-zero blanking.
  always_comb begin
    an_d  = DIGIT_UNITS;
    seg_d = seg_enc(units);
    if (sel_q) begin
      an_d  = DIGIT_TENS;
      seg_d = (BLANK_ZERO && (tens == 4'd0)) ? SEG_BLANK : seg_enc(tens);
    end
  end

  // Refresh and display registers; display is dark during reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      sel_q <= 1'b0;
      seg_q <= SEG_BLANK;
      an_q  <= DIGIT_OFF;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign bcd_tens_o  = tens;
  assign bcd_units_o = units;
  assign seg_o       = seg_q;
  assign an_o        = an_q;

endmodule

// File: tb/tb_module_bin2seg_mux.sv
// Directed bench for module_bin2seg_mux: table of conversions plus
// hand-written sequences for re-sampling, display refresh and mid-conversion reset.
module tb_module_bin2seg_mux;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] count_i = '0;

  logic       busy1, busy0;
  logic [3:0] tens1, units1, tens0, units0;
  logic [6:0] seg1, seg0;
  logic [1:0] an1, an0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  module_bin2seg_mux #(.REFRESH_CYCLES(4), .BLANK_ZERO(1'b1)) dut1 (
    .clk(clk), .rst(rst), .count_i(count_i), .busy_o(busy1),
    .bcd_tens_o(tens1), .bcd_units_o(units1), .seg_o(seg1), .an_o(an1)
  );

  module_bin2seg_mux #(.REFRESH_CYCLES(4), .BLANK_ZERO(1'b0)) dut0 (
    .clk(clk), .rst(rst), .count_i(count_i), .busy_o(busy0),
    .bcd_tens_o(tens0), .bcd_units_o(units0), .seg_o(seg0), .an_o(an0)
  );

  typedef struct {
    logic [5:0] cnt;
    logic [3:0] tens;
    logic [3:0] units;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [3:0] prev_t, prev_u;
    int busy_cnt;
    bit seen;
    logic [1:0] first_an, other_an, exp_an;

    vecs[0] = '{6'd42, 4'd4, 4'd2};
    vecs[1] = '{6'd59, 4'd5, 4'd9};
    vecs[2] = '{6'd63, 4'd6, 4'd3};
    vecs[3] = '{6'd7,  4'd0, 4'd7};
    vecs[4] = '{6'd10, 4'd1, 4'd0};
    vecs[5] = '{6'd0,  4'd0, 4'd0};
    vecs[6] = '{6'd19, 4'd1, 4'd9};
    vecs[7] = '{6'd50, 4'd5, 4'd0};

    // Reset held for three cycles
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_busy_bz0", busy0, 1'b0);
    chk("rst_tens", tens1, 4'd0);
    chk("rst_units", units1, 4'd0);
    chk("rst_seg", seg1, 7'b1111111);
    chk("rst_an", an1, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    chk("first_an", an1, 2'b10);
    chk("first_seg", seg1, 7'b1000000);

    // Table of single conversions: busy width, hold of old value, new value
    prev_t = 4'd0;
    prev_u = 4'd0;
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      count_i  = vecs[v].cnt;
      busy_cnt = 0;
      for (int k = 0; k < 7; k++) begin
        @(negedge clk);
        if (busy1) busy_cnt++;
      end
      chk("hold_tens", tens1, prev_t);
      chk("hold_units", units1, prev_u);
      @(negedge clk);
      chk("conv_tens", tens1, vecs[v].tens);
      chk("conv_units", units1, vecs[v].units);
      chk("busy_low", busy1, 1'b0);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (busy1) busy_cnt++;
      end
      chk("busy_width", busy_cnt, 7);
      prev_t = vecs[v].tens;
      prev_u = vecs[v].units;
    end

    // Input changes mid-conversion: first value finishes, then re-sample
    @(negedge clk);
    count_i = 6'd42;
    repeat (2) @(negedge clk);
    count_i = 6'd17;
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      if (!busy1) seen = 1'b1;
    end
    chk("resample_done", seen, 1'b1);
    chk("resample_first_tens", tens1, 4'd4);
    chk("resample_first_units", units1, 4'd2);
    @(negedge clk);
    chk("resample_busy", busy1, 1'b1);
    repeat (6) @(negedge clk);
    chk("resample_hold_units", units1, 4'd2);
    @(negedge clk);
    chk("resample_tens", tens1, 4'd1);
    chk("resample_units", units1, 4'd7);

    // Display refresh with count 7: units shown as 7, tens blanked or 0
    @(negedge clk);
    count_i = 6'd7;
    repeat (12) @(negedge clk);
    chk("disp_tens", tens1, 4'd0);
    chk("disp_units", units1, 4'd7);
    chk("disp_units_bz0", units0, 4'd7);
    chk("disp_tens_bz0", tens0, 4'd0);
    first_an = an1;
    seen = 1'b0;
    for (int k = 0; k < 9 && !seen; k++) begin
      @(negedge clk);
      if (an1 != first_an) seen = 1'b1;
    end
    chk("an_toggle_seen", seen, 1'b1);
    first_an = an1;
    other_an = (first_an == 2'b10) ? 2'b01 : 2'b10;
    for (int i = 0; i < 16; i++) begin
      exp_an = (((i / 4) % 2) == 0) ? first_an : other_an;
      chk("an_phase", an1, exp_an);
      chk("an_phase_bz0", an0, exp_an);
      if (exp_an == 2'b10) begin
        chk("seg_units", seg1, 7'b1111000);
        chk("seg_units_bz0", seg0, 7'b1111000);
      end else begin
        chk("seg_tens_blank", seg1, 7'b1111111);
        chk("seg_tens_zero", seg0, 7'b1000000);
      end
      @(negedge clk);
    end

    // Reset in the third CONV cycle, then automatic reconversion
    count_i = 6'd35;
    repeat (3) @(negedge clk);
    chk("mid_busy_before", busy1, 1'b1);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy1, 1'b0);
    chk("mid_rst_tens", tens1, 4'd0);
    chk("mid_rst_units", units1, 4'd0);
    chk("mid_rst_seg", seg1, 7'b1111111);
    chk("mid_rst_an", an1, 2'b11);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy1, 1'b1);
    chk("post_rst_an", an1, 2'b10);
    chk("post_rst_seg", seg1, 7'b1000000);
    repeat (6) @(negedge clk);
    chk("post_rst_hold", units1, 4'd0);
    @(negedge clk);
    chk("post_rst_tens", tens1, 4'd3);
    chk("post_rst_units", units1, 4'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
